// File: rtl/instr_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: opcode constants,
// PCSrc encodings, the fetch-state enum and the instruction width.
package instr_fetch_seq_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0] OP_HALT   = 6'b111111;
  localparam logic [5:0] OP_J      = 6'b111000;
  localparam logic [2:0] OP_BR_GRP = 3'b110;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_ISSUE = 2'b01,
    ST_HALT  = 2'b10,
    ST_ERR   = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_seq_next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch or
// region-preserving jump, all modulo 2^32. Reserved PCSrc falls back to pc+4.
module instr_fetch_seq_next_pc_calc
  import instr_fetch_seq_pkg::*;
(
  input  logic [INSTR_W-1:0] cur_pc_i,
  input  logic [25:0]        instr_i,
  input  logic [1:0]         pc_src_i,
  output logic [INSTR_W-1:0] next_pc_o
);

  logic [INSTR_W-1:0] pc_plus4;
  logic [INSTR_W-1:0] br_off;

  assign pc_plus4 = cur_pc_i + 32'd4;
  assign br_off   = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

  // Pick the target for the selected PC source
  always_comb begin
    next_pc_o = pc_plus4;
    unique case (pc_src_i)
      PCSRC_BR:  next_pc_o = pc_plus4 + br_off;
      PCSRC_JMP: next_pc_o = {pc_plus4[31:28], instr_i[25:0], 2'b00};
      default:   next_pc_o = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, fetches words over a req/ack
// handshake, issues them to decode/execute and retires them on instr_done.
// Freezes on a retired halt opcode or on a memory ack timeout.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                imem_req_o,
  output logic [INSTR_W-1:0]  imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [INSTR_W-1:0]  imem_rdata_i,
  output logic                instr_valid_o,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [INSTR_W-1:0]  cur_pc_o,
  input  logic                instr_done_i,
  input  logic                pc_wre_i,
  input  logic [1:0]          pc_src_i,
  output logic                halted_o,
  output logic                fetch_err_o,
  output logic [CNT_W-1:0]    retired_cnt_o
);

  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] cur_pc_q, cur_pc_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] next_pc;

  instr_fetch_seq_next_pc_calc u_next_pc (
    .cur_pc_i  (cur_pc_q),
    .instr_i   (instr_q[25:0]),
    .pc_src_i  (pc_src_i),
    .next_pc_o (next_pc)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  // Datapath registers: pc, fetched word, its address, timeout and retire counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      cur_pc_q <= RESET_PC;
      tmo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cur_pc_q <= cur_pc_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state and register updates; an ack in the last timeout cycle still wins
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cur_pc_d = cur_pc_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack_i) begin
          instr_d  = imem_rdata_i;
          cur_pc_d = pc_q;
          tmo_d    = '0;
          state_d  = ST_ISSUE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_ISSUE: begin
        if (instr_done_i) begin
          if (pc_wre_i) begin
            pc_d = next_pc;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            state_d = (instr_q[31:26] == OP_HALT) ? ST_HALT : ST_FETCH;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  assign imem_req_o    = rst_ni && (state_q == ST_FETCH);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == ST_ISSUE);
  assign instr_o       = instr_q;
  assign cur_pc_o      = cur_pc_q;
  assign halted_o      = (state_q == ST_HALT);
  assign fetch_err_o   = (state_q == ST_ERR);
  assign retired_cnt_o = cnt_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed vector table, hand-written
// halt/timeout/reset sequences, and randomized traffic against a PC model.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rstN;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] curPc;
  logic        instrDone;
  logic        pcWre;
  logic [1:0]  pcSrc;
  logic        halted;
  logic        fetchErr;
  logic [31:0] retiredCnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] word;
    logic        wre;
    logic [1:0]  src;
    logic [31:0] addr;
    logic [31:0] nextAddr;
    logic [31:0] cnt;
    logic        halt;
  } vec_t;

  vec_t vecs[14];

  instr_fetch_seq dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .imem_req_o    (imemReq),
    .imem_addr_o   (imemAddr),
    .imem_ack_i    (imemAck),
    .imem_rdata_i  (imemRdata),
    .instr_valid_o (instrValid),
    .instr_o       (instr),
    .cur_pc_o      (curPc),
    .instr_done_i  (instrDone),
    .pc_wre_i      (pcWre),
    .pc_src_i      (pcSrc),
    .halted_o      (halted),
    .fetch_err_o   (fetchErr),
    .retired_cnt_o (retiredCnt)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck handshake can never hang the run
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Architectural next-PC rule written with plain integer arithmetic
  function automatic logic [31:0] nextPcModel(input logic [31:0] pc, input logic [31:0] w, input logic [1:0] src);
    logic [31:0] p4;
    int off;
    p4 = pc + 32'd4;
    off = int'($signed(w[15:0])) * 4;
    case (src)
      2'b01:   return p4 + 32'(off);
      2'b10:   return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      default: return p4;
    endcase
  endfunction

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    imemAck = 1'b0;
    imemRdata = '0;
    instrDone = 1'b0;
    pcWre = 1'b0;
    pcSrc = 2'b00;
    #1;
    checkOutput("rst_req", 32'(imemReq), 32'd0);
    checkOutput("rst_valid", 32'(instrValid), 32'd0);
    checkOutput("rst_addr", imemAddr, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_cnt", retiredCnt, 32'd0);
    checkOutput("rst_flags", {30'd0, halted, fetchErr}, 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  // One fetch/issue/retire transaction, entered at a negedge with the DUT in FETCH
  task automatic applyStimulus(input logic [31:0] word, input logic wre, input logic [1:0] src,
                               input int ackDelay, input int doneDelay, input logic [31:0] expAddr);
    int n;
    n = 0;
    while (!imemReq && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fetch_req", 32'(imemReq), 32'd1);
    checkOutput("fetch_addr", imemAddr, expAddr);
    for (int i = 0; i < ackDelay; i++) begin
      imemAck = 1'b0;
      instrDone = 1'($urandom);
      pcWre = 1'($urandom);
      @(negedge clk);
      checkOutput("fetch_wait_req", 32'(imemReq), 32'd1);
    end
    imemAck = 1'b1;
    imemRdata = word;
    instrDone = 1'b0;
    @(negedge clk);
    imemAck = 1'b0;
    checkOutput("issue_valid", 32'(instrValid), 32'd1);
    checkOutput("issue_instr", instr, word);
    checkOutput("issue_pc", curPc, expAddr);
    checkOutput("issue_req", 32'(imemReq), 32'd0);
    for (int i = 0; i < doneDelay; i++) begin
      imemAck = 1'($urandom);
      imemRdata = $urandom;
      @(negedge clk);
      checkOutput("issue_hold", instr, word);
    end
    imemAck = 1'b0;
    instrDone = 1'b1;
    pcWre = wre;
    pcSrc = src;
    @(negedge clk);
    instrDone = 1'b0;
    pcWre = 1'b0;
    pcSrc = 2'b00;
  endtask

  initial begin
    logic [31:0] modelPc;
    logic [31:0] modelCnt;
    logic [31:0] w;
    logic        wre;
    logic [1:0]  src;
    int          ackD;

    vecs[0]  = '{32'h0000_0000, 1'b1, 2'b00, 32'h0000_0000, 32'h0000_0004, 32'd1,  1'b0};
    vecs[1]  = '{32'h1234_5678, 1'b1, 2'b00, 32'h0000_0004, 32'h0000_0008, 32'd2,  1'b0};
    vecs[2]  = '{32'hC000_FFFE, 1'b0, 2'b01, 32'h0000_0008, 32'h0000_0008, 32'd2,  1'b0};
    vecs[3]  = '{32'h0000_0001, 1'b1, 2'b00, 32'h0000_0008, 32'h0000_000C, 32'd3,  1'b0};
    vecs[4]  = '{32'h0000_0002, 1'b1, 2'b00, 32'h0000_000C, 32'h0000_0010, 32'd4,  1'b0};
    vecs[5]  = '{32'hC000_FFFE, 1'b1, 2'b01, 32'h0000_0010, 32'h0000_000C, 32'd5,  1'b0};
    vecs[6]  = '{32'h0000_0003, 1'b1, 2'b11, 32'h0000_000C, 32'h0000_0010, 32'd6,  1'b0};
    vecs[7]  = '{32'hC000_0003, 1'b1, 2'b01, 32'h0000_0010, 32'h0000_0020, 32'd7,  1'b0};
    vecs[8]  = '{32'hC000_8000, 1'b1, 2'b01, 32'h0000_0020, 32'hFFFE_0024, 32'd8,  1'b0};
    vecs[9]  = '{32'hE000_0000, 1'b1, 2'b10, 32'hFFFE_0024, 32'hF000_0000, 32'd9,  1'b0};
    vecs[10] = '{32'hE000_0040, 1'b1, 2'b10, 32'hF000_0000, 32'hF000_0100, 32'd10, 1'b0};
    vecs[11] = '{32'hE000_0040, 1'b1, 2'b00, 32'hF000_0100, 32'hF000_0104, 32'd11, 1'b0};
    vecs[12] = '{32'hFC00_0000, 1'b0, 2'b00, 32'hF000_0104, 32'hF000_0104, 32'd11, 1'b0};
    vecs[13] = '{32'hFC00_0000, 1'b1, 2'b00, 32'hF000_0104, 32'hF000_0108, 32'd12, 1'b1};

    rstN = 1'b0;
    imemAck = 1'b0;
    imemRdata = '0;
    instrDone = 1'b0;
    pcWre = 1'b0;
    pcSrc = 2'b00;

    // Directed vector table
    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].word, vecs[i].wre, vecs[i].src, i % 3, i % 2, vecs[i].addr);
      checkOutput($sformatf("vec%0d_next_addr", i), imemAddr, vecs[i].nextAddr);
      checkOutput($sformatf("vec%0d_cnt", i), retiredCnt, vecs[i].cnt);
      checkOutput($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].halt));
    end

    // Halted sequencer ignores acks and done pulses
    checkOutput("halt_req", 32'(imemReq), 32'd0);
    checkOutput("halt_valid", 32'(instrValid), 32'd0);
    checkOutput("halt_err", 32'(fetchErr), 32'd0);
    imemAck = 1'b1;
    imemRdata = 32'h0000_0000;
    instrDone = 1'b1;
    pcWre = 1'b1;
    repeat (3) @(negedge clk);
    imemAck = 1'b0;
    instrDone = 1'b0;
    pcWre = 1'b0;
    checkOutput("halt_frozen_addr", imemAddr, 32'hF000_0108);
    checkOutput("halt_frozen_cnt", retiredCnt, 32'd12);
    checkOutput("halt_still", 32'(halted), 32'd1);
    checkOutput("halt_valid2", 32'(instrValid), 32'd0);

    // No ack: error must appear exactly after the 16th waiting cycle
    doReset();
    repeat (15) @(negedge clk);
    checkOutput("tmo15_err", 32'(fetchErr), 32'd0);
    checkOutput("tmo15_req", 32'(imemReq), 32'd1);
    @(negedge clk);
    checkOutput("tmo16_err", 32'(fetchErr), 32'd1);
    checkOutput("tmo16_req", 32'(imemReq), 32'd0);
    checkOutput("tmo16_addr", imemAddr, 32'h0);
    checkOutput("tmo16_halted", 32'(halted), 32'd0);
    imemAck = 1'b1;
    repeat (2) @(negedge clk);
    imemAck = 1'b0;
    checkOutput("err_frozen", 32'(fetchErr), 32'd1);
    checkOutput("err_valid", 32'(instrValid), 32'd0);

    // Ack on the last allowed cycle wins, then reset mid-issue
    doReset();
    repeat (15) @(negedge clk);
    imemAck = 1'b1;
    imemRdata = 32'h0000_0000;
    @(negedge clk);
    imemAck = 1'b0;
    checkOutput("late_ack_valid", 32'(instrValid), 32'd1);
    checkOutput("late_ack_err", 32'(fetchErr), 32'd0);
    instrDone = 1'b1;
    pcWre = 1'b1;
    pcSrc = 2'b00;
    @(negedge clk);
    instrDone = 1'b0;
    pcWre = 1'b0;
    checkOutput("late_ack_cnt", retiredCnt, 32'd1);
    checkOutput("late_ack_addr", imemAddr, 32'h4);
    imemAck = 1'b1;
    imemRdata = 32'h0000_0010;
    @(negedge clk);
    imemAck = 1'b0;
    checkOutput("mid_issue_valid", 32'(instrValid), 32'd1);
    instrDone = 1'b1;
    pcWre = 1'b1;
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_req", 32'(imemReq), 32'd0);
    checkOutput("mid_rst_valid", 32'(instrValid), 32'd0);
    checkOutput("mid_rst_cnt", retiredCnt, 32'd0);
    checkOutput("mid_rst_addr", imemAddr, 32'h0);
    @(negedge clk);
    instrDone = 1'b0;
    pcWre = 1'b0;

    // Randomized traffic against the PC/counter model
    doReset();
    modelPc = 32'h0;
    modelCnt = 32'd0;
    for (int k = 0; k < 150; k++) begin
      w = $urandom;
      if (w[31:26] == 6'b111111) w[31:26] = 6'b111110;
      wre = ($urandom_range(0, 3) != 0);
      src = 2'($urandom);
      ackD = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4));
      applyStimulus(w, wre, src, ackD, int'($urandom_range(0, 3)), modelPc);
      if (wre) begin
        modelPc = nextPcModel(modelPc, w, src);
        if (modelCnt != 32'hFFFF_FFFF) modelCnt = modelCnt + 32'd1;
      end
      checkOutput("rnd_addr", imemAddr, modelPc);
      checkOutput("rnd_cnt", retiredCnt, modelCnt);
      checkOutput("rnd_flags", {30'd0, halted, fetchErr}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
